// File: rtl/note_feeder_if.sv
// note_feeder_if: lane-side pattern request/hit signals and HUD result bus
interface note_feeder_if;
  logic trocar;
  logic ponto;
  logic [3:0] command_out;
  logic [13:0] score;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic song_done;
  modport master (
    output trocar, ponto,
    input command_out, score, combo, max_combo, song_done
  );
  modport slave (
    input trocar, ponto,
    output command_out, score, combo, max_combo, song_done
  );
endinterface

// File: rtl/note_feeder.sv
// note_feeder: LFSR chord pattern source for the lanes plus score/combo tally
module note_feeder #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int SONG_LEN = 64,
  parameter int MAX_KEYS = 2
) (
  input logic CLOCK_25,
  input logic reset,
  note_feeder_if.slave bus
);
  localparam int IW = $clog2(SONG_LEN + 1);
  localparam logic [IW-1:0] LEN = IW'(SONG_LEN);
  typedef enum logic {PLAYING, DONE} state_t;
  function automatic logic [3:0] pat(input logic [3:0] v);
    logic [3:0] r;
    int n;
    r = '0;
    n = 0;
    for (int i = 0; i < 4; i++)
      if (v[i] && n < MAX_KEYS) begin
        r[i] = 1'b1;
        n++;
      end
    return v == 4'd0 ? 4'b1000 : r;
  endfunction
  state_t r_state, w_state;
  logic [15:0] r_lfsr, w_lfsr, w_step;
  logic [3:0] r_cmd, w_cmd;
  logic [IW-1:0] r_issued, w_issued;
  logic r_hit, w_hit, r_ponto_d, r_done, w_done, w_credit;
  logic [13:0] r_score, w_score, w_score_inc;
  logic [14:0] w_sum;
  logic [7:0] r_combo, w_combo, w_combo_inc, r_max, w_max;
  logic [2:0] w_mult;
  assign w_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_credit = r_state == PLAYING && bus.ponto && !r_ponto_d && !r_hit;
  assign w_combo_inc = r_combo == 8'hFF ? r_combo : r_combo + 8'd1;
  assign w_mult = r_combo >= 8'd24 ? 3'd4 : {1'b0, r_combo[4:3]} + 3'd1;
  assign w_sum = {1'b0, r_score} + {12'd0, w_mult};
  assign w_score_inc = w_sum > 15'd9999 ? 14'd9999 : w_sum[13:0];
  always_comb begin
    w_state = r_state;
    w_lfsr = r_lfsr;
    w_cmd = r_cmd;
    w_issued = r_issued;
    w_hit = r_hit;
    w_score = r_score;
    w_combo = r_combo;
    w_max = r_max;
    w_done = r_done;
    if (r_state == PLAYING) begin
      if (w_credit) begin
        w_hit = 1'b1;
        w_combo = w_combo_inc;
        w_score = w_score_inc;
        w_max = w_combo_inc > r_max ? w_combo_inc : r_max;
      end
      if (bus.trocar) begin
        w_combo = w_hit ? w_combo : 8'd0;
        if (r_issued == LEN) begin
          w_state = DONE;
          w_cmd = 4'd0;
          w_done = 1'b1;
        end else begin
          w_lfsr = w_step;
          w_cmd = pat(w_step[3:0]);
          w_issued = r_issued + IW'(1);
          w_hit = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge CLOCK_25) begin
    r_ponto_d <= reset ? 1'b0 : bus.ponto;
    if (reset) begin
      r_state <= PLAYING;
      r_lfsr <= SEED;
      r_cmd <= pat(SEED[3:0]);
      r_issued <= IW'(1);
      r_hit <= 1'b0;
      r_score <= '0;
      r_combo <= '0;
      r_max <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_lfsr <= w_lfsr;
      r_cmd <= w_cmd;
      r_issued <= w_issued;
      r_hit <= w_hit;
      r_score <= w_score;
      r_combo <= w_combo;
      r_max <= w_max;
      r_done <= w_done;
    end
  end
  assign bus.command_out = r_cmd;
  assign bus.score = r_score;
  assign bus.combo = r_combo;
  assign bus.max_combo = r_max;
  assign bus.song_done = r_done;
endmodule

// File: tb/tb_note_feeder.sv
// tb_note_feeder: four differently parameterised feeders against a behavioural model
module tb_note_feeder;
  localparam logic [15:0] SEEDS [4] = '{16'hACE1, 16'h000B, 16'h0010, 16'hACE1};
  localparam int LENS [4] = '{64, 64, 64, 4};
  localparam int KEYS [4] = '{2, 1, 1, 2};
  typedef struct {
    int lfsr, cmd, issued, score, combo, maxc;
    bit hit, done, pprev;
  } mdl_t;
  logic clk, rst, tr, po;
  logic [3:0] cmd_o [4];
  logic [13:0] sc_o [4];
  logic [7:0] cb_o [4], mx_o [4];
  logic dn_o [4];
  int errs = 0, checks = 0;
  bit armed = 0;
  mdl_t m [4];
  note_feeder_if bus [4] ();
  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus[g].trocar = tr;
    assign bus[g].ponto = po;
    assign cmd_o[g] = bus[g].command_out;
    assign sc_o[g] = bus[g].score;
    assign cb_o[g] = bus[g].combo;
    assign mx_o[g] = bus[g].max_combo;
    assign dn_o[g] = bus[g].song_done;
    note_feeder #(.SEED(SEEDS[g]), .SONG_LEN(LENS[g]), .MAX_KEYS(KEYS[g])) u_dut (
      .CLOCK_25(clk), .reset(rst), .bus(bus[g])
    );
  end
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int pmodel(int v, int mk);
    bit [3:0] x;
    x = 4'(v);
    if (x == 0) return 8;
    while ($countones(x) > mk)
      for (int b = 3; b >= 0; b--)
        if (x[b]) begin
          x[b] = 0;
          break;
        end
    return int'(x);
  endfunction
  function automatic mdl_t step(mdl_t c, bit r, bit t, bit p, int seed, int len, int mk);
    mdl_t n;
    int mult, fb;
    n = c;
    n.pprev = p;
    if (r) begin
      n.lfsr = seed; n.cmd = pmodel(seed % 16, mk); n.issued = 1; n.hit = 0;
      n.score = 0; n.combo = 0; n.maxc = 0; n.done = 0; n.pprev = 0;
      return n;
    end
    if (c.done) return n;
    if (p && !c.pprev && !c.hit) begin
      mult = c.combo < 8 ? 1 : c.combo < 16 ? 2 : c.combo < 24 ? 3 : 4;
      n.score = c.score + mult > 9999 ? 9999 : c.score + mult;
      n.combo = c.combo == 255 ? 255 : c.combo + 1;
      n.maxc = n.combo > c.maxc ? n.combo : c.maxc;
      n.hit = 1;
    end
    if (t) begin
      if (!n.hit) n.combo = 0;
      if (c.issued == len) begin
        n.cmd = 0; n.done = 1;
      end else begin
        fb = ((c.lfsr >> 15) ^ (c.lfsr >> 13) ^ (c.lfsr >> 12) ^ (c.lfsr >> 10)) & 1;
        n.lfsr = ((c.lfsr << 1) | fb) & 16'hFFFF;
        n.cmd = pmodel(n.lfsr % 16, mk);
        n.issued = c.issued + 1;
        n.hit = 0;
      end
    end
    return n;
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 4; k++) m[k] <= step(m[k], rst, tr, po, SEEDS[k], LENS[k], KEYS[k]);
  always @(negedge clk)
    if (armed)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("cmd%0d", k), cmd_o[k], m[k].cmd);
        chk($sformatf("score%0d", k), sc_o[k], m[k].score);
        chk($sformatf("combo%0d", k), cb_o[k], m[k].combo);
        chk($sformatf("maxc%0d", k), mx_o[k], m[k].maxc);
        chk($sformatf("done%0d", k), dn_o[k], m[k].done);
      end
  task automatic drive(bit t, bit p);
    tr = t;
    po = p;
    @(negedge clk);
  endtask
  task automatic reset_dut();
    rst = 1; tr = 0; po = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    rst = 1; tr = 0; po = 0;
    @(negedge clk);
    reset_dut();
    armed = 1;
    chk("rst_cmd_a", cmd_o[0], 1);
    chk("rst_cmd_b", cmd_o[1], 1);
    chk("rst_cmd_c", cmd_o[2], 8);
    chk("rst_score", sc_o[0], 0);
    chk("rst_combo", cb_o[0], 0);
    chk("rst_done", dn_o[0], 0);
    drive(1, 0);
    drive(0, 0);
    chk("first_step_cmd", cmd_o[0], 3);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1);
      drive(0, 0);
      drive(1, 0);
    end
    drive(0, 0);
    chk("len4_not_done", dn_o[3], 0);
    chk("len4_combo", cb_o[3], 2);
    drive(0, 1);
    drive(1, 0);
    drive(0, 0);
    chk("len4_cmd_zero", cmd_o[3], 0);
    chk("len4_done", dn_o[3], 1);
    drive(0, 1);
    drive(1, 0);
    drive(1, 1);
    drive(0, 0);
    chk("len4_frozen_score", sc_o[3], 3);
    chk("len4_frozen_combo", cb_o[3], 3);
    chk("len4_frozen_max", mx_o[3], 3);
    chk("len4_frozen_cmd", cmd_o[3], 0);
    reset_dut();
    chk("len4_reset_cmd", cmd_o[3], 1);
    chk("len4_reset_done", dn_o[3], 0);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 5; j++) drive(0, 1);
      drive(1, 0);
    end
    chk("ten_combo", cb_o[0], 10);
    chk("ten_score", sc_o[0], 12);
    chk("ten_max", mx_o[0], 10);
    drive(1, 0);
    chk("miss_combo", cb_o[0], 0);
    chk("miss_score", sc_o[0], 12);
    chk("miss_max", mx_o[0], 10);
    drive(0, 1);
    drive(1, 1);
    drive(1, 1);
    drive(1, 1);
    drive(0, 0);
    chk("held_score", sc_o[0], 13);
    drive(1, 1);
    chk("simul_combo", cb_o[0], 1);
    drive(0, 0);
    drive(0, 1);
    chk("next_hit_combo", cb_o[0], 2);
    chk("next_hit_score", sc_o[0], 15);
    for (int i = 0; i < 30; i++) begin
      drive(1, 0);
      drive(0, 1);
      drive(0, 0);
    end
    chk("mult_combo", cb_o[0], 32);
    chk("mult_score", sc_o[0], 93);
    chk("mult_max", mx_o[0], 32);
    for (int i = 0; i < 3000; i++)
      if ($urandom_range(0, 699) == 0) reset_dut();
      else drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0 ? !po : po);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
